exc_sequencer: RTL

Exception and interrupt sequencer between the pipeline and the CP0 register block. It synchronizes and latches the six device interrupt lines, gates interrupt and exception codes so CP0 only sees them against a real instruction in M, and drives the pipeline on a taken exception or `eret`: flush, PC redirect, EXL clear. A post-`eret` guard window lets the handler-return target instruction commit before interrupts are re-presented.

---
 rtl/exc_sequencer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/exc_sequencer.sv
// ---------------------------------------------------------------------------
// exc_sequencer
//
// Exception / interrupt sequencer sitting between the pipeline and the CP0
// register block.
//   * Synchronizes the six asynchronous device interrupt lines (2 flops) and
//     presents them to CP0 either as levels or as rising-edge latched
//     pending bits (selected per source by EDGE_MASK).
//   * Gates interrupt lines and the exception code so CP0 only ever sees
//     them against a real instruction in the M stage.
//   * On a taken exception (cp0_req) or an eret in M, flushes the pipeline
//     and redirects the PC in the same cycle; eret also clears EXL.
//   * After an eret, a guard window of GUARD_CYCLES cycles holds the
//     interrupt lines at 0 so the handler-return target instruction can
//     commit before any interrupt is re-presented.
//
// Parameters:
//   HANDLER_PC   : redirect target for a taken exception/interrupt
//   EDGE_MASK    : per source, 1 = rising-edge latched, 0 = level
//   GUARD_CYCLES : length of the post-eret guard window (1..15)
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   hw_int_in    : raw device interrupt lines (asynchronous to clk)
//   m_valid      : M stage holds a real instruction
//   m_exc_code   : exception code of the M-stage instruction (0 = none)
//   m_eret       : M-stage instruction is eret
//   cp0_req      : CP0 take-exception request (combinational from CP0)
//   cp0_epc      : CP0 EPC
//   hw_int_out   : interrupt lines to CP0
//   exc_code_out : exception code to CP0
//   flush        : clear F/D/E/M and suppress the M-stage commit
//   redirect_en  : next-PC override enable
//   redirect_pc  : next-PC override target (0 when redirect_en is 0)
//   exl_clr      : clear EXL in CP0
//   guard        : guard window active
//
// Optional feature, macro EXC_SEQ_STAT_EN: adds saturating 16-bit counters
//   exc_cnt (requests taken with a nonzero exception code) and
//   int_cnt (requests taken with a zero exception code, i.e. interrupts).
// ---------------------------------------------------------------------------
module exc_sequencer #(
    parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
    parameter logic [5:0]  EDGE_MASK    = 6'b000000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hw_int_in,
    input  logic        m_valid,
    input  logic [4:0]  m_exc_code,
    input  logic        m_eret,
    input  logic        cp0_req,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  hw_int_out,
    output logic [4:0]  exc_code_out,
    output logic        flush,
    output logic        redirect_en,
    output logic [31:0] redirect_pc,
    output logic        exl_clr,
    output logic        guard
`ifdef EXC_SEQ_STAT_EN
    ,
    output logic [15:0] exc_cnt,
    output logic [15:0] int_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    localparam logic [3:0] GCNT_LOAD = GUARD_CYCLES[3:0];

    // Synchronizer, edge history and pending bits
    logic [5:0] sync1_q;
    logic [5:0] sync2_q;
    logic [5:0] prev_q;
    logic [5:0] pend_q;
    logic [5:0] pend_d;
    logic [5:0] rise_s;
    logic [5:0] src_s;

    // Guard FSM
    state_t     state_q;
    state_t     state_d;
    logic [3:0] gcnt_q;
    logic [3:0] gcnt_d;

    // Two-flop synchronizer plus one delayed copy for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 6'b000000;
            sync2_q <= 6'b000000;
            prev_q  <= 6'b000000;
        end else begin
            sync1_q <= hw_int_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Edge detect, pending-bit update and per-source selection.
    always_comb begin
        rise_s = sync2_q & ~prev_q;
        // A bit is cleared only when CP0 actually takes it; a new edge on
        // that same clock wins so the fresh request is not lost.
        pend_d = EDGE_MASK & (rise_s | (pend_q & ~({6{cp0_req}} & hw_int_out)));
        src_s  = (EDGE_MASK & pend_q) | (~EDGE_MASK & sync2_q);
    end

    // Pending-bit register for edge-mode sources.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 6'b000000;
        end else begin
            pend_q <= pend_d;
        end
    end

    // CP0-facing gating: nothing is presented against a bubble or in guard.
    always_comb begin
        guard        = (state_q == ST_GUARD);
        hw_int_out   = src_s & {6{m_valid & ~guard}};
        exc_code_out = m_valid ? m_exc_code : 5'd0;
    end

    // Next-state and pipeline-control outputs; cp0_req outranks eret.
    always_comb begin
        state_d     = state_q;
        gcnt_d      = gcnt_q;
        flush       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0000_0000;
        exl_clr     = 1'b0;

        if (cp0_req) begin
            flush       = 1'b1;
            redirect_en = 1'b1;
            redirect_pc = HANDLER_PC;
            state_d     = ST_IDLE;
            gcnt_d      = 4'd0;
        end else if (m_valid && m_eret) begin
            flush       = 1'b1;
            redirect_en = 1'b1;
            redirect_pc = cp0_epc;
            exl_clr     = 1'b1;
            state_d     = ST_GUARD;
            gcnt_d      = GCNT_LOAD;
        end else begin
            case (state_q)
                ST_GUARD: begin
                    // Leave on the 1 -> 0 step; <= 1 also covers a stray 0.
                    if (gcnt_q <= 4'd1) begin
                        gcnt_d  = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        gcnt_d  = gcnt_q - 4'd1;
                        state_d = ST_GUARD;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                    gcnt_d  = 4'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                    gcnt_d  = 4'd0;
                end
            endcase
        end
    end

    // FSM state and guard counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
        end
    end

`ifdef EXC_SEQ_STAT_EN
    logic [15:0] exc_cnt_q;
    logic [15:0] exc_cnt_d;
    logic [15:0] int_cnt_q;
    logic [15:0] int_cnt_d;

    // Saturating statistics: classify each taken request by the gated code.
    always_comb begin
        exc_cnt_d = exc_cnt_q;
        int_cnt_d = int_cnt_q;
        if (cp0_req && (exc_code_out != 5'd0)) begin
            if (exc_cnt_q != 16'hFFFF) begin
                exc_cnt_d = exc_cnt_q + 16'd1;
            end else begin
                exc_cnt_d = exc_cnt_q;
            end
        end else if (cp0_req) begin
            if (int_cnt_q != 16'hFFFF) begin
                int_cnt_d = int_cnt_q + 16'd1;
            end else begin
                int_cnt_d = int_cnt_q;
            end
        end else begin
            exc_cnt_d = exc_cnt_q;
            int_cnt_d = int_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_cnt_q <= 16'd0;
            int_cnt_q <= 16'd0;
        end else begin
            exc_cnt_q <= exc_cnt_d;
            int_cnt_q <= int_cnt_d;
        end
    end

    assign exc_cnt = exc_cnt_q;
    assign int_cnt = int_cnt_q;
`endif

endmodule
